// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC channel sequencer: result word layout and
// channel-map lookup.
package adc_seq_pkg;

  localparam int unsigned CHAN_BITS = 5;
  localparam int unsigned MAX_SLOTS = 16;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned MAP_W     = MAX_SLOTS * CHAN_BITS;

  localparam int unsigned SLOT_LSB = 24;
  localparam int unsigned CHAN_LSB = 16;
  localparam int unsigned DATA_LSB = 0;

  typedef struct packed {
    logic [7:0]           slot;
    logic [2:0]           rsvd;
    logic [CHAN_BITS-1:0] chan;
    logic [15:0]          data;
  } result_word_t;

  // ADC channel number held in a packed map for one slot.
  function automatic logic [CHAN_BITS-1:0] map_entry(input logic [MAP_W-1:0] map,
                                                     input logic [IDX_W-1:0] slot);
    return map[32'(slot) * CHAN_BITS +: CHAN_BITS];
  endfunction

endpackage

// File: rtl/adc_channel_sequencer_result_fifo.sv
// Synchronous FIFO with full/empty flags and a stb/ack read port; head reads
// as zero when empty.
module result_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_stb_o,
  input  logic             rd_ack_i,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_c, pop_c;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign rd_stb_o  = ~empty_o;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign pop_c     = rd_ack_i & ~empty_o;
  // A write into a full FIFO is accepted only when a pop frees the slot.
  assign push_c    = wr_en_i & (~full_o | pop_c);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/adc_channel_sequencer.sv
// Round-robin ADC command sequencer with per-slot averaging and a tagged
// result stream towards the control CPU.
module adc_channel_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned                     CHANNELS    = 4,
  parameter logic [CHANNELS*CHAN_BITS-1:0]   CHANNEL_MAP = {5'd4, 5'd3, 5'd2, 5'd1},
  parameter int unsigned                     DATA_WIDTH  = 12,
  parameter int unsigned                     AVG_LOG2    = 4,
  parameter int unsigned                     FIFO_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  output logic                  command_valid,
  output logic [CHAN_BITS-1:0]  command_channel,
  output logic                  command_startofpacket,
  output logic                  command_endofpacket,
  input  logic                  command_ready,
  input  logic                  response_valid,
  input  logic [CHAN_BITS-1:0]  response_channel,
  input  logic [DATA_WIDTH-1:0] response_data,
  output logic [31:0]           out,
  output logic                  out_stb,
  input  logic                  out_ack,
  output logic                  overflow,
  output logic                  sync_error
);

  localparam int unsigned ACC_W  = DATA_WIDTH + AVG_LOG2;
  localparam int unsigned CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned WORD_W = $bits(result_word_t);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
  localparam logic [MAP_W-1:0] MAP_EXT  = MAP_W'(CHANNEL_MAP);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic                 rst_q;
  logic [IDX_W-1:0]     cmd_idx_q, cmd_idx_d;
  logic [IDX_W-1:0]     rsp_idx_q, rsp_idx_d;
  logic [ACC_W-1:0]     acc_q [CHANNELS];
  logic [ACC_W-1:0]     acc_d [CHANNELS];
  logic [CNT_W-1:0]     cnt_q [CHANNELS];
  logic [CNT_W-1:0]     cnt_d [CHANNELS];
  logic                 push_q, push_d;
  result_word_t         push_word_q, push_word_d;
  logic                 overflow_q, overflow_d;
  logic                 sync_error_q, sync_error_d;

  logic [CHAN_BITS-1:0]  exp_chan_c;
  logic [ACC_W-1:0]      acc_sel_c, sum_c;
  logic [CNT_W-1:0]      cnt_sel_c;
  logic [DATA_WIDTH-1:0] avg_c;
  logic                  match_c, done_c;
  logic                  fifo_full, fifo_empty;
  logic [WORD_W-1:0]     fifo_head;

  // Command issue is held off for one cycle after reset releases.
  assign command_valid         = enable & ~rst_q;
  assign command_channel       = map_entry(MAP_EXT, cmd_idx_q);
  assign command_startofpacket = command_valid;
  assign command_endofpacket   = command_valid;

  assign exp_chan_c = map_entry(MAP_EXT, rsp_idx_q);
  assign match_c    = response_valid & (response_channel == exp_chan_c);

  always_comb begin
    acc_sel_c = '0;
    cnt_sel_c = '0;
    for (int s = 0; s < int'(CHANNELS); s++) begin
      if (rsp_idx_q == IDX_W'(s)) begin
        acc_sel_c = acc_q[s];
        cnt_sel_c = cnt_q[s];
      end
    end
  end

  assign sum_c  = acc_sel_c + ACC_W'(response_data);
  assign done_c = (AVG_LOG2 == 0) || (cnt_sel_c == CNT_LAST);
  assign avg_c  = DATA_WIDTH'(sum_c >> AVG_LOG2);

  // Next-state: slot pointers, accumulators, result staging and sticky flags.
  always_comb begin
    cmd_idx_d    = cmd_idx_q;
    rsp_idx_d    = rsp_idx_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    push_d       = 1'b0;
    push_word_d  = result_word_t'((32'(rsp_idx_q) << SLOT_LSB) |
                                  (32'(exp_chan_c) << CHAN_LSB) |
                                  (32'(avg_c) << DATA_LSB));
    overflow_d   = overflow_q | (push_q & fifo_full & ~(out_ack & ~fifo_empty));
    sync_error_d = sync_error_q;

    if (command_valid && command_ready) begin
      cmd_idx_d = (cmd_idx_q == LAST_IDX) ? '0 : cmd_idx_q + IDX_W'(1);
    end
    // Every response consumes a slot, even discarded ones, to stay in issue order.
    if (response_valid) begin
      rsp_idx_d = (rsp_idx_q == LAST_IDX) ? '0 : rsp_idx_q + IDX_W'(1);
    end

    if (clear) begin
      for (int s = 0; s < int'(CHANNELS); s++) begin
        acc_d[s] = '0;
        cnt_d[s] = '0;
      end
      overflow_d   = 1'b0;
      sync_error_d = 1'b0;
    end else if (response_valid) begin
      if (!match_c) begin
        sync_error_d = 1'b1;
      end else begin
        for (int s = 0; s < int'(CHANNELS); s++) begin
          if (rsp_idx_q == IDX_W'(s)) begin
            if (done_c) begin
              acc_d[s] = '0;
              cnt_d[s] = '0;
              push_d   = 1'b1;
            end else begin
              acc_d[s] = sum_c;
              cnt_d[s] = cnt_sel_c + CNT_W'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      cmd_idx_q    <= '0;
      rsp_idx_q    <= '0;
      push_q       <= 1'b0;
      push_word_q  <= '0;
      overflow_q   <= 1'b0;
      sync_error_q <= 1'b0;
      for (int s = 0; s < int'(CHANNELS); s++) begin
        acc_q[s] <= '0;
        cnt_q[s] <= '0;
      end
    end else begin
      cmd_idx_q    <= cmd_idx_d;
      rsp_idx_q    <= rsp_idx_d;
      push_q       <= push_d;
      push_word_q  <= push_word_d;
      overflow_q   <= overflow_d;
      sync_error_q <= sync_error_d;
      for (int s = 0; s < int'(CHANNELS); s++) begin
        acc_q[s] <= acc_d[s];
        cnt_q[s] <= cnt_d[s];
      end
    end
  end

  result_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (clear),
    .wr_en_i   (push_q),
    .wr_data_i (push_word_q),
    .rd_data_o (fifo_head),
    .rd_stb_o  (out_stb),
    .rd_ack_i  (out_ack),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign out        = fifo_head;
  assign overflow   = overflow_q;
  assign sync_error = sync_error_q;

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// Bench for adc_channel_sequencer: two instances (averaging over 4 and
// pass-through) share stimulus and are checked every cycle against a model.
module tb_adc_channel_sequencer;

  localparam int NCH   = 2;
  localparam int DW    = 12;
  localparam int DEPTH = 8;
  localparam logic [9:0] MAP = {5'd3, 5'd1};

  logic clk = 1'b0;
  logic rst = 1'b1, enable = 1'b0, clear = 1'b0, command_ready = 1'b0;
  logic response_valid = 1'b0, out_ack = 1'b0;
  logic [4:0]    response_channel = '0;
  logic [DW-1:0] response_data = '0;

  logic        cv   [2];
  logic [4:0]  cch  [2];
  logic        sop  [2];
  logic        eop  [2];
  logic [31:0] o_out[2];
  logic        o_stb[2];
  logic        o_ovf[2];
  logic        o_sync[2];

  always #5 clk = ~clk;

  adc_channel_sequencer #(.CHANNELS(NCH), .CHANNEL_MAP(MAP), .DATA_WIDTH(DW),
                          .AVG_LOG2(2), .FIFO_DEPTH(DEPTH)) u_avg (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .command_valid(cv[0]), .command_channel(cch[0]),
    .command_startofpacket(sop[0]), .command_endofpacket(eop[0]),
    .command_ready(command_ready), .response_valid(response_valid),
    .response_channel(response_channel), .response_data(response_data),
    .out(o_out[0]), .out_stb(o_stb[0]), .out_ack(out_ack),
    .overflow(o_ovf[0]), .sync_error(o_sync[0]));

  adc_channel_sequencer #(.CHANNELS(NCH), .CHANNEL_MAP(MAP), .DATA_WIDTH(DW),
                          .AVG_LOG2(0), .FIFO_DEPTH(DEPTH)) u_raw (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .command_valid(cv[1]), .command_channel(cch[1]),
    .command_startofpacket(sop[1]), .command_endofpacket(eop[1]),
    .command_ready(command_ready), .response_valid(response_valid),
    .response_channel(response_channel), .response_data(response_data),
    .out(o_out[1]), .out_stb(o_stb[1]), .out_ack(out_ack),
    .overflow(o_ovf[1]), .sync_error(o_sync[1]));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int          rstq_m = 1, cmd_idx_m = 0, rsp_idx_m = 0;
  int          acc_m [2][NCH];
  int          cnt_m [2][NCH];
  bit          pend_m [2];
  logic [31:0] pendw_m [2];
  logic [31:0] q_m [2][$];
  bit          ovf_m [2];
  bit          sync_m [2];
  int          inflight [$];

  function automatic int chan_of(input int s);
    logic [9:0] m;
    m = MAP;
    return int'((m >> (5 * s)) & 10'h1f);
  endfunction

  function automatic int avg_log2(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] @%0t: got %h expected %h", nm, inst, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    bit exp_cv;
    exp_cv = enable && (rstq_m == 0);
    for (int i = 0; i < 2; i++) begin
      chk("command_valid", i, 32'(cv[i]), 32'(exp_cv));
      if (exp_cv) begin
        chk("command_channel", i, 32'(cch[i]), 32'(chan_of(cmd_idx_m)));
        chk("sop", i, 32'(sop[i]), 32'd1);
        chk("eop", i, 32'(eop[i]), 32'd1);
      end
      chk("out_stb", i, 32'(o_stb[i]), 32'(q_m[i].size() > 0));
      chk("out", i, o_out[i], (q_m[i].size() > 0) ? q_m[i][0] : 32'd0);
      chk("overflow", i, 32'(o_ovf[i]), 32'(ovf_m[i]));
      chk("sync_error", i, 32'(o_sync[i]), 32'(sync_m[i]));
    end
  endtask

  task automatic model_reset();
    cmd_idx_m = 0;
    rsp_idx_m = 0;
    for (int i = 0; i < 2; i++) begin
      q_m[i].delete();
      pend_m[i] = 0;
      ovf_m[i]  = 0;
      sync_m[i] = 0;
      for (int s = 0; s < NCH; s++) begin
        acc_m[i][s] = 0;
        cnt_m[i][s] = 0;
      end
    end
  endtask

  // Applies the inputs present at this clock edge to the model.
  task automatic model_edge();
    bit exp_cv;
    int s, n;
    exp_cv = enable && (rstq_m == 0);
    if (exp_cv && command_ready) inflight.push_back(chan_of(cmd_idx_m));
    if (rst) begin
      model_reset();
      rstq_m = 1;
      return;
    end
    if (exp_cv && command_ready) cmd_idx_m = (cmd_idx_m + 1) % NCH;
    for (int i = 0; i < 2; i++) begin
      if (clear) begin
        q_m[i].delete();
        pend_m[i] = 0;
        ovf_m[i]  = 0;
        sync_m[i] = 0;
        for (int k = 0; k < NCH; k++) begin
          acc_m[i][k] = 0;
          cnt_m[i][k] = 0;
        end
      end else begin
        if (q_m[i].size() > 0 && out_ack) void'(q_m[i].pop_front());
        if (pend_m[i]) begin
          if (q_m[i].size() < DEPTH) q_m[i].push_back(pendw_m[i]);
          else ovf_m[i] = 1;
        end
        pend_m[i] = 0;
        if (response_valid) begin
          s = rsp_idx_m;
          if (int'(response_channel) == chan_of(s)) begin
            n = 1 << avg_log2(i);
            acc_m[i][s] += int'(response_data);
            cnt_m[i][s]++;
            if (cnt_m[i][s] == n) begin
              pend_m[i]  = 1;
              pendw_m[i] = (32'(s) << 24) | (32'(chan_of(s)) << 16) | 32'(acc_m[i][s] / n);
              acc_m[i][s] = 0;
              cnt_m[i][s] = 0;
            end
          end else begin
            sync_m[i] = 1;
          end
        end
      end
    end
    if (response_valid) rsp_idx_m = (rsp_idx_m + 1) % NCH;
    rstq_m = 0;
  endtask

  task automatic tick();
    #1 compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send(input int ch, input int data, input bit ack);
    response_valid   = 1'b1;
    response_channel = 5'(ch);
    response_data    = DW'(data);
    out_ack          = ack;
    tick();
    response_valid = 1'b0;
    out_ack        = 1'b0;
  endtask

  task automatic drain();
    out_ack = 1'b1;
    repeat (DEPTH + 2) tick();
    out_ack = 1'b0;
  endtask

  int ack_pct;
  int ch;

  initial begin
    model_reset();
    @(posedge clk);
    model_edge();
    #1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("idle_cv", 0, 32'(cv[0]), 32'd0);
    chk("idle_stb", 0, 32'(o_stb[0]), 32'd0);
    chk("idle_ovf", 0, 32'(o_ovf[0]), 32'd0);
    chk("idle_sync", 0, 32'(o_sync[0]), 32'd0);
    tick();

    // Averaging: slot 0 gets 100..103, slot 1 gets 200,200,201,202
    send(1, 100, 0); send(3, 200, 0); send(1, 101, 0); send(3, 200, 0);
    send(1, 102, 0); send(3, 201, 0); send(1, 103, 0); send(3, 202, 0);
    tick(); tick();
    #1;
    chk("avg_slot0", 0, o_out[0], 32'h0001_0065);
    chk("raw_first", 1, o_out[1], 32'h0001_0064);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    #1;
    chk("avg_slot1", 0, o_out[0], 32'h0103_00C8);
    drain();

    // Pass-through latency
    send(1, 'hFFF, 0);
    #1 chk("lat1_stb", 1, 32'(o_stb[1]), 32'd0);
    tick();
    #1 chk("lat2_out", 1, o_out[1], 32'h0001_0FFF);
    drain();

    // FIFO full: 8 queued, 9th dropped, 10th accepted with coincident pop
    for (int k = 0; k < 9; k++) send(chan_of(rsp_idx_m), 16 + k, 0);
    tick();
    #1 chk("full_ovf", 1, 32'(o_ovf[1]), 32'd1);
    send(chan_of(rsp_idx_m), 99, 0);
    out_ack = 1'b1;
    tick();
    repeat (7) tick();
    #1 chk("occ_after7", 1, 32'(o_stb[1]), 32'd1);
    tick();
    #1 chk("occ_after8", 1, 32'(o_stb[1]), 32'd0);
    drain();

    // Channel mismatch and clear
    if (rsp_idx_m != 0) send(chan_of(rsp_idx_m), 5, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    chk("clr_ovf", 1, 32'(o_ovf[1]), 32'd0);
    chk("clr_stb", 1, 32'(o_stb[1]), 32'd0);
    send(7, 50, 0);
    #1 chk("mismatch_sync", 0, 32'(o_sync[0]), 32'd1);
    send(3, 'h123, 0);
    tick();
    #1 chk("next_slot1", 1, o_out[1], 32'h0103_0123);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    chk("clr_sync", 0, 32'(o_sync[0]), 32'd0);
    chk("clr_empty", 1, 32'(o_stb[1]), 32'd0);
    tick();

    // Enable drop with two commands in flight
    enable = 1'b1;
    command_ready = 1'b1;
    tick(); tick();
    enable = 1'b0;
    command_ready = 1'b0;
    tick();
    #1 chk("drop_cv", 0, 32'(cv[0]), 32'd0);
    while (inflight.size() > 0) begin
      ch = inflight.pop_front();
      send(ch, (ch == 1) ? 'h200 : 'h300, 0);
      tick();
    end
    tick();
    #1 chk("drop_rsp0", 1, o_out[1], 32'h0001_0200);
    drain();

    // Randomized traffic
    ack_pct = 70;
    for (int c = 0; c < 3000; c++) begin
      if (c % 256 == 0) ack_pct = $urandom_range(0, 2) * 45;
      enable        = ($urandom_range(0, 9) != 0);
      command_ready = 1'($urandom_range(0, 1));
      out_ack       = ($urandom_range(0, 99) < ack_pct);
      clear         = ($urandom_range(0, 199) == 0);
      rst           = (inflight.size() == 0) && ($urandom_range(0, 499) == 0);
      if (rst) command_ready = 1'b0;
      response_valid = 1'b0;
      if (!rst && inflight.size() > 0 && $urandom_range(0, 2) != 0) begin
        ch = inflight.pop_front();
        if ($urandom_range(0, 39) == 0) ch = ch ^ 16;
        response_valid   = 1'b1;
        response_channel = 5'(ch);
        response_data    = DW'($urandom);
      end
      tick();
    end
    rst = 1'b0; clear = 1'b0; enable = 1'b0; command_ready = 1'b0;
    response_valid = 1'b0; out_ack = 1'b0;
    tick();
    while (inflight.size() > 0) begin
      ch = inflight.pop_front();
      send(ch, $urandom_range(0, 4095), 0);
    end
    drain();

    // Reset with a command in flight
    enable = 1'b1;
    command_ready = 1'b1;
    tick();
    enable = 1'b0;
    command_ready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    while (inflight.size() > 0) begin
      ch = inflight.pop_front();
      send(ch, 'h7AB, 0);
    end
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
